alu_op_sequencer: RTL

Synthesizable micro-sequencer that drives the `Datapath` control inputs through one register-register or register-immediate ALU operation. It can also preload register-file entries through the memory-data/write-back path. It generalises the fixed load-load-load-AND-writeback sequence into a reusable block: run-time operands, opcode and immediate select, an optional second write-back of the high result half (MUL/DIV), a ready/valid command handshake, and a wrapping completed-operation counter. It sits between a bench or boot controller and `Datapath`, ahead of the full control unit.

---
 rtl/alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: walks the Datapath control inputs through one ALU operation
//   (fetch/decode/exec/write-back lo [/hi]) or a register-file preload.
// Latency: preload 2 busy cycles, op 6 (8 with high-half write-back) incl. DONE.
// Backpressure: oReady is high only in IDLE; requests are taken only then, and
//   preload wins over start (start must be held until it is accepted).
//
// Ports:
//   iClk, iRst                  clock, synchronous active-high reset
//   iPreValid/iPreAddr/iPreData preload request (write iPreData into RF[iPreAddr])
//   iStart + command fields     operation request (opcode, Ra/Rb/Rc, imm, hi half)
//   oReady, oDone               handshake / completion pulse
//   o* Datapath drives          decoded from state + latched command
//   oOpCount                    wrapping count of completed operations

module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 4,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  // preload request
  input  logic              iPreValid,
  input  logic [RF_AW-1:0]  iPreAddr,
  input  logic [DATA_W-1:0] iPreData,
  // operation request
  input  logic              iStart,
  input  logic [CTRL_W-1:0] iOpCtrl,
  input  logic [RF_AW-1:0]  iRa,
  input  logic [RF_AW-1:0]  iRb,
  input  logic [RF_AW-1:0]  iRc,
  input  logic              iUseImm,
  input  logic [DATA_W-1:0] iImm,
  input  logic              iHiEn,
  input  logic [RF_AW-1:0]  iRcHi,
  // handshake
  output logic              oReady,
  output logic              oDone,
  // Datapath drives
  output logic [DATA_W-1:0] oMemData,
  output logic              oPC_nRst,
  output logic              oPC_en,
  output logic              oPC_jmp,
  output logic              oMUX_MAP,
  output logic [RF_AW-1:0]  oRF_AddrA,
  output logic [RF_AW-1:0]  oRF_AddrB,
  output logic [RF_AW-1:0]  oRF_AddrC,
  output logic              oRF_Write,
  output logic              oRWB_en,
  output logic              oRA_en,
  output logic              oRB_en,
  output logic              oRZH_en,
  output logic              oRZL_en,
  output logic [CTRL_W-1:0] oALU_Ctrl,
  output logic [DATA_W-1:0] oImm32,
  output logic              oMUX_BIS,
  output logic              oMUX_RZHS,
  output logic              oMUX_WBM,
  output logic              oMUX_WBP,
  output logic              oMUX_ASS,
  // statistics
  output logic [CNT_W-1:0]  oOpCount
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PRE_A  = 4'd1,
    S_PRE_B  = 4'd2,
    S_FETCH  = 4'd3,
    S_DECODE = 4'd4,
    S_EXEC   = 4'd5,
    S_WB_LO  = 4'd6,
    S_WR_LO  = 4'd7,
    S_WB_HI  = 4'd8,
    S_WR_HI  = 4'd9,
    S_DONE   = 4'd10
  } state_e;

  state_e state_q, state_d;

  // latched preload request
  logic [RF_AW-1:0]  pre_addr_q, pre_addr_d;
  logic [DATA_W-1:0] pre_data_q, pre_data_d;

  // latched operation command
  logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
  logic [RF_AW-1:0]  ra_q, ra_d;
  logic [RF_AW-1:0]  rb_q, rb_d;
  logic [RF_AW-1:0]  rc_q, rc_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              hi_en_q, hi_en_d;
  logic [RF_AW-1:0]  rc_hi_q, rc_hi_d;

  // PC reset release is sticky: once the first fetch happened the PC keeps running
  logic              pc_live_q, pc_live_d;

  logic [CNT_W-1:0]  op_count_q, op_count_d;

  // ---------------------------------------------------------------------------
  // State and command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      pre_addr_q <= '0;
      pre_data_q <= '0;
      op_ctrl_q  <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      hi_en_q    <= 1'b0;
      rc_hi_q    <= '0;
      pc_live_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pre_addr_q <= pre_addr_d;
      pre_data_q <= pre_data_d;
      op_ctrl_q  <= op_ctrl_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      use_imm_q  <= use_imm_d;
      imm_q      <= imm_d;
      hi_en_q    <= hi_en_d;
      rc_hi_q    <= rc_hi_d;
      pc_live_q  <= pc_live_d;
      op_count_q <= op_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, request capture and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pre_addr_d = pre_addr_q;
    pre_data_d = pre_data_q;
    op_ctrl_d  = op_ctrl_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rc_d       = rc_q;
    use_imm_d  = use_imm_q;
    imm_d      = imm_q;
    hi_en_d    = hi_en_q;
    rc_hi_d    = rc_hi_q;
    pc_live_d  = pc_live_q;
    op_count_d = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        // Preload takes priority; a concurrent start stays pending on its input.
        if (iPreValid) begin
          pre_addr_d = iPreAddr;
          pre_data_d = iPreData;
          state_d    = S_PRE_A;
        end else if (iStart) begin
          op_ctrl_d = iOpCtrl;
          ra_d      = iRa;
          rb_d      = iRb;
          rc_d      = iRc;
          use_imm_d = iUseImm;
          imm_d     = iImm;
          hi_en_d   = iHiEn;
          rc_hi_d   = iRcHi;
          state_d   = S_FETCH;
        end
      end
      S_PRE_A:  state_d = S_PRE_B;
      S_PRE_B:  state_d = S_IDLE;
      S_FETCH: begin
        pc_live_d = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB_LO;
      S_WB_LO:  state_d = S_WR_LO;
      S_WR_LO:  state_d = hi_en_q ? S_WB_HI : S_DONE;
      S_WB_HI:  state_d = S_WR_HI;
      S_WR_HI:  state_d = S_DONE;
      S_DONE: begin
        // Counter wraps naturally at its width.
        op_count_d = op_count_q + 1'b1;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (pure function of state and latched fields)
  // ---------------------------------------------------------------------------
  logic hold_win;

  always_comb begin
    // Opcode, immediate and B-select are held stable across the whole
    // decode..write-back window so the Datapath sees no glitching mid-op.
    hold_win = (state_q == S_DECODE) || (state_q == S_EXEC)  ||
               (state_q == S_WB_LO)  || (state_q == S_WR_LO) ||
               (state_q == S_WB_HI)  || (state_q == S_WR_HI);

    oReady    = 1'b0;
    oDone     = 1'b0;
    oMemData  = '0;
    oPC_nRst  = pc_live_q;
    oPC_en    = 1'b0;
    oPC_jmp   = 1'b0;
    oMUX_MAP  = 1'b0;
    oRF_AddrA = '0;
    oRF_AddrB = '0;
    oRF_AddrC = '0;
    oRF_Write = 1'b0;
    oRWB_en   = 1'b0;
    oRA_en    = 1'b0;
    oRB_en    = 1'b0;
    oRZH_en   = 1'b0;
    oRZL_en   = 1'b0;
    oALU_Ctrl = hold_win ? op_ctrl_q : '0;
    oImm32    = hold_win ? imm_q     : '0;
    oMUX_BIS  = hold_win ? use_imm_q : 1'b0;
    oMUX_RZHS = 1'b0;
    oMUX_WBM  = 1'b0;
    oMUX_WBP  = 1'b0;
    oMUX_ASS  = 1'b0;

    unique case (state_q)
      S_IDLE: oReady = 1'b1;
      S_PRE_A: begin
        // Memory-data path feeds the write-back register.
        oMemData = pre_data_q;
        oMUX_WBM = 1'b1;
        oRWB_en  = 1'b1;
      end
      S_PRE_B: begin
        oRF_AddrC = pre_addr_q;
        oRF_Write = 1'b1;
      end
      S_FETCH: begin
        oPC_nRst = 1'b1;
        oPC_en   = 1'b1;
        oPC_jmp  = 1'b1;
        oMUX_MAP = 1'b1;
      end
      S_DECODE: begin
        oRF_AddrA = ra_q;
        oRF_AddrB = rb_q;
        oRA_en    = 1'b1;
        oRB_en    = 1'b1;
      end
      S_EXEC: begin
        oRZH_en = 1'b1;
        oRZL_en = 1'b1;
      end
      S_WB_LO: begin
        // ALU low half through write-back; all write-back muxes at 0.
        oRWB_en = 1'b1;
      end
      S_WR_LO: begin
        oRF_AddrC = rc_q;
        oRF_Write = 1'b1;
      end
      S_WB_HI: begin
        oRWB_en   = 1'b1;
        oMUX_RZHS = 1'b1;
      end
      S_WR_HI: begin
        // Written after the low half, so Rc == RcHi leaves the high half.
        oRF_AddrC = rc_hi_q;
        oRF_Write = 1'b1;
      end
      S_DONE:  oDone = 1'b1;
      default: ;
    endcase
  end

  assign oOpCount = op_count_q;

endmodule
